// File: rtl/reg_read_port_pkg.sv
// Shared widths and FSM state type for the register read port.
package reg_pkg;
  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 16;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } rd_state_e;
endpackage

// File: rtl/reg_read_port_if.sv
// Request/bus signal bundle between a reader (master) and reg_read_port (slave).
interface reg_read_port_if;
  import reg_pkg::*;

  logic                rd_req;
  logic [NUM_REGS-1:0] rd_sel;
  logic                rd_ready;
  logic [DATA_W-1:0]   bus_out;
  logic                bus_oe;
  logic                rd_done;
  logic                rd_err;

  modport master (output rd_req, rd_sel,
                  input  rd_ready, bus_out, bus_oe, rd_done, rd_err);
  modport slave  (input  rd_req, rd_sel,
                  output rd_ready, bus_out, bus_oe, rd_done, rd_err);
endinterface

// File: rtl/reg_read_port_onehot_mux8.sv
// 8:1 register select; lowest set bit wins, plus an exactly-one-hot flag.
module onehot_mux8
  import reg_pkg::*;
(
  input  logic [NUM_REGS-1:0] sel_i,
  input  logic [DATA_W-1:0]   regs_i [NUM_REGS],
  output logic [DATA_W-1:0]   data_o,
  output logic                onehot_o
);

  always_comb begin
    data_o = '0;
    // walk downward so the lowest set bit is assigned last
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (sel_i[i]) data_o = regs_i[i];
    end
  end

  assign onehot_o = (sel_i != '0) && ((sel_i & (sel_i - 1'b1)) == '0);

endmodule

// File: rtl/reg_read_port.sv
// Register read port: captures one of r0..r7 and drives it for HOLD_CYCLES, then pulses rd_done.
// Optional REG_READ_ONEHOT_CHK_EN rejects selects that are not exactly one-hot (rd_err).
module reg_read_port
  import reg_pkg::*;
#(
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_read_port_if.slave    rd_if,
  input  logic [DATA_W-1:0] r0_i,
  input  logic [DATA_W-1:0] r1_i,
  input  logic [DATA_W-1:0] r2_i,
  input  logic [DATA_W-1:0] r3_i,
  input  logic [DATA_W-1:0] r4_i,
  input  logic [DATA_W-1:0] r5_i,
  input  logic [DATA_W-1:0] r6_i,
  input  logic [DATA_W-1:0] r7_i
);

`ifdef REG_READ_ONEHOT_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  rd_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  bus_out_q, bus_out_d;
  logic               bus_oe_q, bus_oe_d;
  logic               rd_ready_q, rd_ready_d;
  logic               rd_done_q, rd_done_d;
  logic               rd_err_q, rd_err_d;

  logic [DATA_W-1:0]  regs [NUM_REGS];
  logic [DATA_W-1:0]  sel_data;
  logic               sel_valid;
  logic               bad_sel;

  assign regs[0] = r0_i;
  assign regs[1] = r1_i;
  assign regs[2] = r2_i;
  assign regs[3] = r3_i;
  assign regs[4] = r4_i;
  assign regs[5] = r5_i;
  assign regs[6] = r6_i;
  assign regs[7] = r7_i;

  onehot_mux8 u_mux (
    .sel_i    (rd_if.rd_sel),
    .regs_i   (regs),
    .data_o   (sel_data),
    .onehot_o (sel_valid)
  );

  assign bad_sel = CHK_EN && !sel_valid;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    rd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_if.rd_req) begin
          if (bad_sel) begin
            state_d  = ST_DONE;
            rd_err_d = 1'b1;
          end else begin
            state_d = ST_DRIVE;
            data_d  = sel_data;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // outputs are registered, so derive them from the next state
    rd_ready_d = (state_d == ST_IDLE);
    bus_oe_d   = (state_d == ST_DRIVE);
    bus_out_d  = (state_d == ST_DRIVE) ? data_d : '0;
    rd_done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      bus_out_q  <= '0;
      bus_oe_q   <= 1'b0;
      rd_ready_q <= 1'b1;
      rd_done_q  <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      rd_ready_q <= rd_ready_d;
      rd_done_q  <= rd_done_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_if.rd_ready = rd_ready_q;
  assign rd_if.bus_out  = bus_out_q;
  assign rd_if.bus_oe   = bus_oe_q;
  assign rd_if.rd_done  = rd_done_q;
  assign rd_if.rd_err   = rd_err_q;

endmodule

// File: tb/tb_reg_read_port.sv
// Bench for reg_read_port: three instances (HOLD_CYCLES 1, 3, 4) in lockstep against a read-timeline model.
module tb_reg_read_port;

`ifdef REG_READ_ONEHOT_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [7:0]  sel;
  logic [15:0] r [8];

  int n_assert = 0;
  int n_fail   = 0;

  // model: ph = cycles since accept (0 idle, 1..H driving, H+1 done pulse)
  int          hh [3] = '{1, 3, 4};
  int          ph [3];
  logic [15:0] md [3];
  logic        me [3];

  always #5 clk = ~clk;

  reg_read_port_if if1 ();
  reg_read_port_if if3 ();
  reg_read_port_if if4 ();

  assign if1.rd_req = req;  assign if1.rd_sel = sel;
  assign if3.rd_req = req;  assign if3.rd_sel = sel;
  assign if4.rd_req = req;  assign if4.rd_sel = sel;

  reg_read_port #(.HOLD_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rd_if(if1.slave),
    .r0_i(r[0]), .r1_i(r[1]), .r2_i(r[2]), .r3_i(r[3]),
    .r4_i(r[4]), .r5_i(r[5]), .r6_i(r[6]), .r7_i(r[7]));

  reg_read_port #(.HOLD_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .rd_if(if3.slave),
    .r0_i(r[0]), .r1_i(r[1]), .r2_i(r[2]), .r3_i(r[3]),
    .r4_i(r[4]), .r5_i(r[5]), .r6_i(r[6]), .r7_i(r[7]));

  reg_read_port #(.HOLD_CYCLES(4)) u4 (
    .clk(clk), .rst_n(rst_n), .rd_if(if4.slave),
    .r0_i(r[0]), .r1_i(r[1]), .r2_i(r[2]), .r3_i(r[3]),
    .r4_i(r[4]), .r5_i(r[5]), .r6_i(r[6]), .r7_i(r[7]));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input int i, input logic oe, input logic [15:0] bo,
                          input logic rdy, input logic dn, input logic er);
    logic e_oe, e_dn;
    e_oe = (ph[i] >= 1) && (ph[i] <= hh[i]);
    e_dn = (ph[i] == hh[i] + 1);
    chk($sformatf("h%0d_bus_oe @%0t", hh[i], $time), 16'(oe), 16'(e_oe));
    chk($sformatf("h%0d_bus_out @%0t", hh[i], $time), bo, e_oe ? md[i] : 16'h0000);
    chk($sformatf("h%0d_rd_ready @%0t", hh[i], $time), 16'(rdy), 16'(ph[i] == 0));
    chk($sformatf("h%0d_rd_done @%0t", hh[i], $time), 16'(dn), 16'(e_dn));
    chk($sformatf("h%0d_rd_err @%0t", hh[i], $time), 16'(er), 16'(e_dn && me[i]));
  endtask

  task automatic check_all();
    chk_inst(0, if1.bus_oe, if1.bus_out, if1.rd_ready, if1.rd_done, if1.rd_err);
    chk_inst(1, if3.bus_oe, if3.bus_out, if3.rd_ready, if3.rd_done, if3.rd_err);
    chk_inst(2, if4.bus_oe, if4.bus_out, if4.rd_ready, if4.rd_done, if4.rd_err);
  endtask

  function automatic logic [15:0] pick(input logic [7:0] s);
    for (int k = 0; k < 8; k++) if (s[k]) return r[k];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ph[i] = 0; md[i] = 16'h0000; me[i] = 1'b0;
    end
  endtask

  task automatic advance(input logic req_v, input logic [7:0] sel_v);
    for (int i = 0; i < 3; i++) begin
      if (ph[i] == 0) begin
        if (req_v) begin
          if (CHK && $countones(sel_v) != 1) begin
            ph[i] = hh[i] + 1; me[i] = 1'b1;
          end else begin
            md[i] = pick(sel_v); me[i] = 1'b0; ph[i] = 1;
          end
        end
      end else if (ph[i] <= hh[i]) begin
        ph[i]++;
      end else begin
        ph[i] = 0;
      end
    end
  endtask

  // called at a falling edge: drive inputs, predict, cross the rising edge, check
  task automatic cycle(input logic req_v, input logic [7:0] sel_v);
    req = req_v;
    sel = sel_v;
    advance(req_v, sel_v);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    sel   = 8'h00;
    for (int k = 0; k < 8; k++) r[k] = 16'(k * 16'h1111);
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // single read of r2
    r[2] = 16'hBEEF;
    cycle(1'b1, 8'h04);
    idle(6);

    // r7 captured at accept; later change must not reach the bus
    r[7] = 16'h1234;
    cycle(1'b1, 8'h80);
    cycle(1'b0, 8'h00);
    r[7] = 16'hFFFF;
    idle(6);

    // rd_req held continuously
    for (int k = 0; k < 30; k++) cycle(1'b1, 8'h01);
    idle(6);

    // multi-bit select
    r[0] = 16'hA5A5;
    r[1] = 16'h5A5A;
    cycle(1'b1, 8'h03);
    idle(6);

    // empty select
    cycle(1'b1, 8'h00);
    idle(6);

    // reset in the second DRIVE cycle of the HOLD_CYCLES=4 instance
    r[1] = 16'hC0DE;
    cycle(1'b1, 8'h02);
    cycle(1'b0, 8'h00);
    chk("h4_in_drive_before_reset", 16'(if4.bus_oe), 16'h0001);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();
    idle(6);

    // random traffic with register contents churning underneath
    for (int k = 0; k < 400; k++) begin
      logic       rq;
      logic [7:0] sv;
      rq = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       sv = 8'h00;
        1:       sv = 8'($urandom);
        default: sv = 8'(1 << $urandom_range(0, 7));
      endcase
      r[$urandom_range(0, 7)] = 16'($urandom);
      cycle(rq, sv);
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
